// File: rtl/exe_stage_mc.sv
// exe_stage_mc: MIPS execute stage with forwarding, ALU, branch unit and the EXE/MEM register.
// Define MULDIV_EN to build the iterative mul/divu/remu unit; otherwise ops 9-11 give 0 in one cycle.
module exe_stage_mc #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CMD_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              freeze,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              wb_en_in,
  input  logic [1:0]        mem_cmd_in,
  input  logic [CMD_W-1:0]  exe_cmd_in,
  input  logic [DATA_W-1:0] val1_in,
  input  logic [DATA_W-1:0] val2_in,
  input  logic [DATA_W-1:0] reg2_in,
  input  logic [REG_AW-1:0] src1_in,
  input  logic [REG_AW-1:0] src2_in,
  input  logic [REG_AW-1:0] dst_in,
  input  logic              is_imm_in,
  input  logic [REG_AW-1:0] dst_mem,
  input  logic [REG_AW-1:0] dst_wb,
  input  logic              wb_en_mem,
  input  logic              wb_en_wb,
  input  logic [DATA_W-1:0] res_mem,
  input  logic [DATA_W-1:0] res_wb,
  output logic              stall_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] pc_out,
  output logic              wb_en_out,
  output logic [1:0]        mem_cmd_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] st_val_out,
  output logic [REG_AW-1:0] dst_out,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_addr
);
  localparam int SH_W = $clog2(DATA_W);
  function automatic logic [DATA_W-1:0] fwd(input logic [REG_AW-1:0] src, input logic [DATA_W-1:0] base);
    return (wb_en_mem && dst_mem != '0 && dst_mem == src) ? res_mem :
           (wb_en_wb && dst_wb != '0 && dst_wb == src) ? res_wb : base;
  endfunction
  logic [3:0]        w_op;
  logic [1:0]        w_bt;
  logic [DATA_W-1:0] w_fwd1, w_fwd2, w_fwdr, w_alu, w_br_addr;
  logic [SH_W-1:0]   w_sh;
  logic              w_md_op, w_md_go, w_taken, w_ld;
  assign w_op      = 4'(exe_cmd_in[CMD_W-1:2]);
  assign w_bt      = exe_cmd_in[1:0];
  assign w_fwd1    = fwd(src1_in, val1_in);
  assign w_fwd2    = is_imm_in ? val2_in : fwd(src2_in, val2_in);
  assign w_fwdr    = fwd(src2_in, reg2_in);
  assign w_sh      = w_fwd2[SH_W-1:0];
  assign w_md_op   = w_op == 4'd9 || w_op == 4'd10 || w_op == 4'd11;
  assign w_taken   = !w_md_op && (w_bt == 2'd3 || (w_bt == 2'd1 && w_fwd1 == w_fwdr) ||
                                  (w_bt == 2'd2 && w_fwd1 != w_fwdr));
  assign w_br_addr = pc_in + (val2_in << 2);
  assign w_ld      = in_valid && !w_md_go;
  always_comb begin
    w_alu = '0;
    case (w_op)
      4'd0: w_alu = w_fwd1 + w_fwd2;
      4'd1: w_alu = w_fwd1 - w_fwd2;
      4'd2: w_alu = w_fwd1 & w_fwd2;
      4'd3: w_alu = w_fwd1 | w_fwd2;
      4'd4: w_alu = ~(w_fwd1 | w_fwd2);
      4'd5: w_alu = w_fwd1 ^ w_fwd2;
      4'd6: w_alu = w_fwd1 << w_sh;
      4'd7: w_alu = $unsigned($signed(w_fwd1) >>> w_sh);
      4'd8: w_alu = w_fwd1 >> w_sh;
      default: w_alu = '0;
    endcase
  end
`ifdef MULDIV_EN
  typedef enum logic {IDLE, RUN} state_t;
  state_t            r_state;
  logic [SH_W-1:0]   r_cnt;
  logic [DATA_W-1:0] r_a, r_b, r_acc;
  logic [1:0]        r_md, r_mem_cmd;
  logic              r_wb_en;
  logic [DATA_W-1:0] w_mul_acc, w_div_q, w_div_rem, w_md_res;
  logic [DATA_W:0]   w_dsh, w_dsub;
  // r_b shifts out MSB-first: multiplier bits for mul, dividend bits (becoming quotient) for div
  assign w_mul_acc = {r_acc[DATA_W-2:0], 1'b0} + (r_b[DATA_W-1] ? r_a : '0);
  assign w_dsh     = {r_acc, r_b[DATA_W-1]};
  assign w_dsub    = w_dsh - {1'b0, r_a};
  assign w_div_rem = w_dsub[DATA_W] ? w_dsh[DATA_W-1:0] : w_dsub[DATA_W-1:0];
  assign w_div_q   = {r_b[DATA_W-2:0], ~w_dsub[DATA_W]};
  assign w_md_res  = r_md == 2'd1 ? w_mul_acc : r_md == 2'd2 ? w_div_q : w_div_rem;
  assign w_md_go   = in_valid && w_md_op && r_state == IDLE;
  assign stall_out = (r_state == RUN) | freeze;
`else
  assign w_md_go   = 1'b0;
  assign stall_out = freeze;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      pc_out      <= '0;
      wb_en_out   <= 1'b0;
      mem_cmd_out <= 2'b00;
      alu_res_out <= '0;
      st_val_out  <= '0;
      dst_out     <= '0;
      br_taken    <= 1'b0;
      br_addr     <= '0;
`ifdef MULDIV_EN
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_md        <= 2'b00;
      r_mem_cmd   <= 2'b00;
      r_wb_en     <= 1'b0;
`endif
    end else if (!freeze) begin
`ifdef MULDIV_EN
      if (r_state == RUN) begin
        r_acc <= r_md == 2'd1 ? w_mul_acc : w_div_rem;
        r_b   <= r_md == 2'd1 ? {r_b[DATA_W-2:0], 1'b0} : w_div_q;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == '0) begin
          r_state     <= IDLE;
          out_valid   <= 1'b1;
          wb_en_out   <= r_wb_en;
          mem_cmd_out <= r_mem_cmd;
          alu_res_out <= w_md_res;
        end
      end else begin
        if (w_md_go) begin
          r_state   <= RUN;
          r_cnt     <= SH_W'(DATA_W - 1);
          r_a       <= w_fwd2;
          r_b       <= w_fwd1;
          r_acc     <= '0;
          r_md      <= w_op[1:0];
          r_wb_en   <= wb_en_in;
          r_mem_cmd <= mem_cmd_in;
        end
`endif
        out_valid   <= w_ld;
        pc_out      <= pc_in;
        wb_en_out   <= w_ld && wb_en_in;
        mem_cmd_out <= w_ld ? mem_cmd_in : 2'b00;
        alu_res_out <= w_alu;
        st_val_out  <= w_fwdr;
        dst_out     <= dst_in;
        br_taken    <= in_valid && w_taken;
        br_addr     <= w_br_addr;
`ifdef MULDIV_EN
      end
`endif
    end
  end
endmodule
